mult_arbiter: RTL and testbench

MULT_ARBITER -- requirements
Module: mult_arbiter

---
 rtl/mult_arb_pkg.sv | 15 +
 rtl/rr_picker.sv | 31 +++
 rtl/mult_arbiter.sv | 138 +++++++++++++
 tb/tb_mult_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and default sizing for the multiplier arbiter.
package mult_arb_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int W_DEF       = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/rr_picker.sv
// Round-robin selector: searches upward from last_served+1 (mod NREQ) for the first active request.
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_served,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_served) + k) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one external multiplier among NREQ requesters: round-robin grant, start, wait with timeout, respond.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int W       = W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              m_start,
    output logic              m_reset,
    output logic [W-1:0]      m_inp1,
    output logic [W-1:0]      m_inp2,
    input  logic              m_done,
    input  logic [W-1:0]      m_result
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   last_q, last_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    res_q, res_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req         (req),
        .last_served (last_q),
        .grant       (pick_gnt),
        .idx         (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        m_start = 1'b0;
        m_reset = rst;
        unique case (state_q)
            ST_IDLE: begin
                if (|pick_gnt) begin
                    idx_d   = pick_idx;
                    a_d     = op_a[int'(pick_idx)*W +: W];
                    b_d     = op_b[int'(pick_idx)*W +: W];
                    gnt_d   = pick_gnt;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                m_start = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the last allowed cycle beats the timeout.
                if (m_done) begin
                    res_d   = m_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    m_reset = 1'b1;
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                last_d  = idx_q;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; the reset is synchronous, sampled on the edge.
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            a_q     <= '0;
            b_q     <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // The grant shows in the selecting IDLE cycle, then holds from the register until RESP ends.
    assign gnt      = (state_q == ST_IDLE && !rst) ? pick_gnt : gnt_q;
    assign busy     = (state_q != ST_IDLE);
    assign m_inp1   = busy ? a_q : '0;
    assign m_inp2   = busy ? b_q : '0;
    assign rsp_data = (state_q == ST_RESP) ? res_q : '0;
    assign rsp_err  = (state_q == ST_RESP) ? err_q : 1'b0;

    always_comb begin
        rsp_valid = '0;
        if (state_q == ST_RESP) rsp_valid[idx_q] = 1'b1;
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multiplier stub.
module tb_mult_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] op_a, op_b;
    logic [NREQ-1:0]   gnt, rsp_valid;
    logic [W-1:0]      rsp_data, m_inp1, m_inp2, m_result;
    logic              rsp_err, busy, m_start, m_reset, m_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .m_start   (m_start),
        .m_reset   (m_reset),
        .m_inp1    (m_inp1),
        .m_inp2    (m_inp2),
        .m_done    (m_done),
        .m_result  (m_result)
    );

    // Multiplier stub: m_done stub_delay cycles after m_start, product truncated to W bits.
    logic        stub_active = 1'b0;
    int          stub_cyc    = 0;
    int          stub_delay  = 5;
    bit          stub_never  = 1'b0;
    bit          stray_done  = 1'b0;
    logic [31:0] prod;

    always @(posedge clk) begin
        if (m_reset) begin
            stub_active <= 1'b0;
        end else if (m_start) begin
            stub_active <= 1'b1;
            stub_cyc    <= 1;
        end else if (stub_active) begin
            stub_cyc <= stub_cyc + 1;
            if (m_done) stub_active <= 1'b0;
        end
    end

    assign prod     = {16'b0, m_inp1} * {16'b0, m_inp2};
    assign m_result = prod[15:0];
    assign m_done   = (stub_active && !stub_never && stub_cyc == stub_delay) || stray_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One job: present requests in IDLE, then follow it until rsp_valid, with a bounded wait.
    task automatic run_job(input logic [3:0] rv, input logic [63:0] av, input logic [63:0] bv,
                           input int idx, input logic [15:0] dv, input logic ev, input int lat,
                           input int mr_exp, input int mr_at, input bit drop);
        logic [15:0] ea, eb;
        int ms, mr, mr_cyc;
        bit seen;
        ea = av[idx*16 +: 16];
        eb = bv[idx*16 +: 16];
        ms = 0; mr = 0; mr_cyc = -1; seen = 1'b0;
        @(negedge clk);
        req = rv; op_a = av; op_b = bv;
        #1;
        check("grant", gnt, 64'(1 << idx));
        check("idle_busy", busy, 0);
        check("idle_inp1", m_inp1, 0);
        check("idle_rsp", rsp_valid, 0);
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            if (drop && c == 1) req = '0;
            #1;
            if (c == 1) begin
                check("issue_start", m_start, 1);
                check("issue_gnt", gnt, 64'(1 << idx));
                check("issue_inp1", m_inp1, ea);
                check("issue_inp2", m_inp2, eb);
            end
            if (m_start) ms++;
            if (m_reset) begin mr++; mr_cyc = c; end
            if (rsp_valid != 0) begin
                seen = 1'b1;
                check("rsp_latency", c, lat);
                check("rsp_valid", rsp_valid, 64'(1 << idx));
                check("rsp_data", rsp_data, dv);
                check("rsp_err", rsp_err, ev);
            end
        end
        if (!seen) check("rsp_seen", 0, 1);
        check("start_pulses", ms, 1);
        check("mreset_pulses", mr, mr_exp);
        if (mr_exp != 0) check("mreset_cycle", mr_cyc, mr_at);
    endtask

    typedef struct {
        logic [3:0]  rv;
        logic [63:0] av;
        logic [63:0] bv;
        int          idx;
        logic [15:0] dv;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{4'b0001, {48'd0, 16'd3}, {48'd0, 16'd7}, 0, 16'd21};
        vecs[1] = '{4'b1111, {16'd255, 16'd100, 16'd10, 16'd5}, {16'd257, 16'd200, 16'd11, 16'd6}, 1, 16'd110};
        vecs[2] = '{4'b1111, {16'd255, 16'd100, 16'd10, 16'd5}, {16'd257, 16'd200, 16'd11, 16'd6}, 2, 16'd20000};
        vecs[3] = '{4'b1111, {16'd255, 16'd100, 16'd10, 16'd5}, {16'd257, 16'd200, 16'd11, 16'd6}, 3, 16'd65535};
        vecs[4] = '{4'b1111, {16'd255, 16'd100, 16'd10, 16'd5}, {16'd257, 16'd200, 16'd11, 16'd6}, 0, 16'd30};
        vecs[5] = '{4'b1001, {16'd255, 16'd100, 16'd10, 16'd5}, {16'd257, 16'd200, 16'd11, 16'd6}, 3, 16'd65535};
        vecs[6] = '{4'b1001, {16'd255, 16'd100, 16'd10, 16'd5}, {16'd257, 16'd200, 16'd11, 16'd6}, 0, 16'd30};
        vecs[7] = '{4'b0100, {16'd0, 16'hFFFF, 32'd0}, {16'd0, 16'd3, 32'd0}, 2, 16'hFFFD};
        vecs[8] = '{4'b0110, {16'd0, 16'd9, 16'd300, 16'd0}, {16'd0, 16'd9, 16'd300, 16'd0}, 1, 16'd24464};

        rst = 1'b1; req = '0; op_a = '0; op_b = '0;
        @(negedge clk);
        #1;
        check("rst_mreset", m_reset, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_start", m_start, 0);
        check("rst_mreset_low", m_reset, 0);
        check("rst_inp", {m_inp1, m_inp2}, 0);

        for (int i = 0; i < 9; i++)
            run_job(vecs[i].rv, vecs[i].av, vecs[i].bv, vecs[i].idx, vecs[i].dv, 1'b0, 7, 0, 0, 1'b0);

        // Stray completion while idle must be ignored.
        @(negedge clk);
        req = '0; stray_done = 1'b1;
        #1;
        check("stray_rsp", rsp_valid, 0);
        @(negedge clk);
        stray_done = 1'b0;
        #1;
        check("stray_busy", busy, 0);
        check("stray_rsp2", rsp_valid, 0);

        // Request dropped right after its grant: job still answered, no re-grant.
        run_job(4'b0010, {32'd0, 16'd12, 16'd0}, {32'd0, 16'd12, 16'd0}, 1, 16'd144, 1'b0, 7, 0, 0, 1'b1);
        @(negedge clk);
        #1;
        check("drop_no_regrant", gnt, 0);
        check("drop_idle", busy, 0);

        // Timeout, then a normal job.
        stub_never = 1'b1;
        run_job(4'b0001, {48'd0, 16'd4}, {48'd0, 16'd5}, 0, 16'd0, 1'b1, 66, 1, 65, 1'b0);
        stub_never = 1'b0;
        run_job(4'b0001, {48'd0, 16'd4}, {48'd0, 16'd5}, 0, 16'd20, 1'b0, 7, 0, 0, 1'b0);

        // Completion in the same cycle as the timeout.
        stub_delay = 64;
        run_job(4'b1000, {16'd1000, 48'd0}, {16'd3, 48'd0}, 3, 16'd3000, 1'b0, 66, 0, 0, 1'b0);
        stub_delay = 5;

        // Reset during WAIT of a job from requester 2.
        @(negedge clk);
        req = 4'b0100; op_a = {16'd0, 16'd7, 32'd0}; op_b = {16'd0, 16'd7, 32'd0};
        #1;
        check("mid_grant", gnt, 4'b0100);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; req = '0;
        #1;
        check("mid_busy", busy, 1);
        check("mid_mreset", m_reset, 1);
        check("mid_rsp", rsp_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_after_busy", busy, 0);
        check("mid_after_rsp", rsp_valid, 0);
        check("mid_after_inp", m_inp1, 0);
        run_job(4'b0101, {16'd0, 16'd8, 16'd0, 16'd2}, {16'd0, 16'd8, 16'd0, 16'd9}, 0, 16'd18, 1'b0, 7, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
